// File: rtl/pipo_ser_pkg.sv
// Shared types and constants for the PIPO serializer.
// Optional parity bit is enabled with PIPO_SER_PARITY_EN.
package pipo_ser_pkg;

`ifdef PIPO_SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
  localparam bit PARITY_EN = 1'b1;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int unsigned DEFAULT_W = 16;

  function automatic int unsigned frame_len(input int unsigned w, input bit parity);
    return parity ? w + 1 : w;
  endfunction

endpackage

// File: rtl/pipo_ser_bitcnt.sv
// Bit counter for the serializer: clear on load, count while shifting,
// saturate at the terminal count W-1.
module pipo_ser_bitcnt #(
  parameter int unsigned W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(W);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pipo_serializer.sv
// Parallel-in/serial-out serializer: one W-bit word per frame, one bit per clock.
// Define PIPO_SER_PARITY_EN to append an even-parity bit to each frame.
module pipo_serializer
  import pipo_ser_pkg::*;
#(
  parameter int unsigned W         = DEFAULT_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         ld,
  output logic         busy,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  state_t         state, state_nxt;
  logic [W-1:0]   shreg;
  logic           load, shifting, tc, done_nxt;

  assign load     = (state == IDLE) && ld;
  assign shifting = (state == SHIFT);

  pipo_ser_bitcnt #(.W(W)) u_bitcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (shifting),
    .tc    (tc)
  );

`ifdef PIPO_SER_PARITY_EN
  logic par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^din;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    sout       = 1'b0;
    busy       = (state != IDLE);
    sout_valid = (state != IDLE);
    case (state)
      IDLE: begin
        if (ld) state_nxt = SHIFT;
      end
      SHIFT: begin
        sout = MSB_FIRST ? shreg[W-1] : shreg[0];
        if (tc) begin
`ifdef PIPO_SER_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end
      end
`ifdef PIPO_SER_PARITY_EN
      PAR: begin
        sout      = par;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (load) begin
        shreg <= din;
      end else if (shifting) begin
        // Shift toward whichever end feeds sout; vacated bits fill with 0.
        if (MSB_FIRST) shreg <= {shreg[W-2:0], 1'b0};
        else           shreg <= {1'b0, shreg[W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_pipo_serializer.sv
// Scoreboard bench for pipo_serializer: MSB-first and LSB-first instances share stimulus.
// Builds with or without PIPO_SER_PARITY_EN.
module tb_pipo_serializer;

  localparam int unsigned W = 16;
`ifdef PIPO_SER_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  din = '0;
  logic          ld = 1'b0;
  logic          busy_m, sout_m, vld_m, done_m;
  logic          busy_l, sout_l, vld_l, done_l;

  int total = 0;
  int bad = 0;

  bit q_m[$];
  bit q_l[$];
  bit dq_m[$];
  bit dq_l[$];
  int nb_m = 0;
  int nb_l = 0;

  always #5 clk = ~clk;

  pipo_serializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .ld(ld),
    .busy(busy_m), .sout(sout_m), .sout_valid(vld_m), .done(done_m)
  );

  pipo_serializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .ld(ld),
    .busy(busy_l), .sout(sout_l), .sout_valid(vld_l), .done(done_l)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) q_m.push_back(w[i]);
    for (int i = 0; i < int'(W); i++) q_l.push_back(w[i]);
`ifdef PIPO_SER_PARITY_EN
    q_m.push_back(^w);
    q_l.push_back(^w);
`endif
    dq_m.push_back(1'b1);
    dq_l.push_back(1'b1);
  endtask

  task automatic flush_expected();
    q_m.delete();
    q_l.delete();
    dq_m.delete();
    dq_l.delete();
  endtask

  // MSB-first monitor
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      nb_m = 0;
    end else begin
      if (vld_m) begin
        chk("msb_bit_expected", 32'(q_m.size() != 0), 32'd1);
        if (q_m.size() != 0) chk("msb_bit", 32'(sout_m), 32'(q_m.pop_front()));
        nb_m++;
      end else begin
        chk("msb_sout_idle_low", 32'(sout_m), 32'd0);
      end
      if (done_m) begin
        chk("msb_done_expected", 32'(dq_m.size() != 0), 32'd1);
        if (dq_m.size() != 0) void'(dq_m.pop_front());
        chk("msb_frame_len", 32'(nb_m), 32'(FL));
        chk("msb_done_idle", {30'd0, busy_m, vld_m}, 32'd0);
        nb_m = 0;
      end
    end
  end

  // LSB-first monitor
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      nb_l = 0;
    end else begin
      if (vld_l) begin
        chk("lsb_bit_expected", 32'(q_l.size() != 0), 32'd1);
        if (q_l.size() != 0) chk("lsb_bit", 32'(sout_l), 32'(q_l.pop_front()));
        nb_l++;
      end else begin
        chk("lsb_sout_idle_low", 32'(sout_l), 32'd0);
      end
      if (done_l) begin
        chk("lsb_done_expected", 32'(dq_l.size() != 0), 32'd1);
        if (dq_l.size() != 0) void'(dq_l.pop_front());
        chk("lsb_frame_len", 32'(nb_l), 32'(FL));
        chk("lsb_done_idle", {30'd0, busy_l, vld_l}, 32'd0);
        nb_l = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    @(negedge clk);
    din = w;
    ld  = 1'b1;
    push_frame(w);
    @(posedge clk);
    #1;
    chk("first_bit_latency", {30'd0, vld_m, vld_l}, 32'd3);
    @(negedge clk);
    ld  = 1'b0;
    din = '0;
  endtask

  task automatic expect_idle(input string name);
    repeat (FL + 3) @(negedge clk);
    chk(name, {30'd0, busy_m, busy_l}, 32'd0);
  endtask

  initial begin
    // Reset held with ld high: nothing may start
    rst_n = 1'b0;
    ld    = 1'b1;
    din   = 16'hA5C3;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {24'd0, busy_m, sout_m, vld_m, done_m, busy_l, sout_l, vld_l, done_l}, 32'd0);
    end
    push_frame(16'hA5C3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_bit_after_reset", {30'd0, vld_m, vld_l}, 32'd3);
    @(negedge clk);
    ld = 1'b0;
    expect_idle("idle_after_a5c3");

    // Load ignored while busy
    send(16'h1234);
    repeat (4) @(negedge clk);
    din = 16'hFFFF;
    ld  = 1'b1;
    @(negedge clk);
    chk("busy_during_ignored_ld", {30'd0, busy_m, busy_l}, 32'd3);
    ld  = 1'b0;
    din = '0;
    expect_idle("idle_after_1234");

    // Back-to-back with ld held high: two frames, one idle cycle between
    @(negedge clk);
    din = 16'h8001;
    ld  = 1'b1;
    push_frame(16'h8001);
    push_frame(16'h8001);
    repeat (FL + 2) @(negedge clk);
    ld  = 1'b0;
    din = '0;
    expect_idle("idle_after_b2b");

    // Reset mid-frame
    send(16'h5A5A);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {24'd0, busy_m, sout_m, vld_m, done_m, busy_l, sout_l, vld_l, done_l}, 32'd0);
    flush_expected();
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("idle_after_reset");

`ifdef PIPO_SER_PARITY_EN
    send(16'h0001);
    expect_idle("idle_after_par1");
    send(16'h0003);
    expect_idle("idle_after_par0");
`endif

    send(16'hC35A);
    expect_idle("idle_after_c35a");

    chk("msb_queue_drained", 32'(q_m.size()), 32'd0);
    chk("lsb_queue_drained", 32'(q_l.size()), 32'd0);
    chk("msb_done_drained", 32'(dq_m.size()), 32'd0);
    chk("lsb_done_drained", 32'(dq_l.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipo_serializer.md
# pipo_serializer

Parallel-in/serial-out serializer that turns a 16-bit parallel word, as captured by the team's parallel load registers, into a bit stream. It is the transmit-side counterpart to the parallel capture path. A word is accepted on a load strobe, shifted out one bit per clock with a valid qualifier, and completion is flagged with a one-cycle pulse. It sits between the parallel datapath registers and any serial link or pin driver.

## Interface
- W, 16, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order: 1 transmits din[W-1] first; 0 transmits din[0] first.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  parallel word. Sampled only on an accepted load.
- ld  input  1  load request. Accepted only while busy = 0.
- busy  output  1  high while a frame is in progress.
- sout  output  1  current serial bit. Driven low when sout_valid = 0.
- sout_valid  output  1  qualifies sout. High for exactly one clock per transmitted bit.
- done  output  1  one-cycle pulse in the cycle after the last bit of a frame.

## Operation
- **Reset values:** busy = 0, sout = 0, sout_valid = 0, done = 0. The shift register, bit counter and parity register are all 0, and the state is IDLE.
- **State machine states:** IDLE, SHIFT, PAR. PAR exists only with PIPO_SER_PARITY_EN.
- **IDLE:**
  - ld = 1 at a rising edge loads shreg <= din and cnt <= 0, then moves to SHIFT.
  - ld = 0 keeps the state in IDLE.
- **SHIFT:**
  - sout = shreg[W-1] when MSB_FIRST = 1, or shreg[0] when MSB_FIRST = 0.
  - Each edge shifts shreg by one toward the output end and fills with 0; cnt increments.
  - At the edge where cnt = W-1, the state moves to PAR (parity build) or to IDLE (no parity).
- **PAR:** sout = stored parity bit for one cycle, then the state moves to IDLE.
- **done:** registered. Set on the edge that leaves the final data or parity cycle, cleared on the next edge.
- **busy:** equals (state != IDLE).
- **ld while busy:** ignored. The word is dropped, the frame in progress is unaffected, and no error is flagged.
- **ld held high continuously:** a new frame loads in the cycle where done = 1 (state is IDLE). This gives exactly one idle cycle between frames.
- **din changing mid-frame:** no effect, since din is sampled only at load.
- **rst_n asserted mid-frame:** all outputs clear immediately (asynchronous). The frame is abandoned and no done pulse is generated.
- **Counter:** cnt is $clog2(W) bits wide. Terminal count is W-1, with no wrap beyond it.

## Timing
- ld is sampled high in IDLE at edge k.
- sout_valid is high during cycles k+1 .. k+W. With parity, this extends to k+W+1.
- done is high in cycle k+W+1, or k+W+2 with parity.
- busy is high during cycles k+1 .. k+W, or k+W+1 with parity.
- Latency from load edge to first bit on sout is 1 cycle.
- Throughput is W bits per W+1 cycles, or W+1 bits per W+2 cycles with parity.
- All outputs are registered or decoded from registered state only. There is no combinational path from ld or din to any output.

## Configuration
- **Macro:** PIPO_SER_PARITY_EN.
- **Defined:** even parity is computed over din at load time (^din) and stored. It is appended as one extra bit after the data in state PAR, so the frame is W+1 bits.
- **Undefined:** the PAR state, the parity register and the parity logic are absent. The frame is exactly W bits.

## Structure
- **Package pipo_ser_pkg:**
  - State typedef: enum IDLE/SHIFT/PAR, 2 bits.
  - Constant for the default width, 16.
  - Function returning frame length given W and the parity setting.
- **Sub-module pipo_ser_bitcnt:**
  - Parameterised up-counter with clear and enable.
  - Terminal-count output tc = (cnt == W-1).
  - Asynchronous active-low reset.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with ld = 1 -> busy, sout, sout_valid and done all 0 throughout. No frame starts until rst_n = 1 and the first edge after it.
- **MSB-first frame:** MSB_FIRST = 1, din = 16'hA5C3, ld pulsed 1 cycle -> sout = 1010 0101 1100 0011 over 16 valid cycles, then done high for exactly 1 cycle.
- **LSB-first frame:** MSB_FIRST = 0, din = 16'hA5C3 -> first 8 bits are 1,1,0,0,0,0,1,1. Total of 16 valid bits, then done.
- **ld while busy:** din = 16'h1234 loaded, ld pulsed with din = 16'hFFFF at bit 5 -> the 0x1234 sequence completes unchanged and no second frame follows.
- **Back-to-back and reset mid-frame:**
  - ld held high with din = 16'h8001 -> frames repeat with exactly one idle cycle, in which done = 1.
  - rst_n pulsed low after bit 5 -> outputs clear immediately and no done pulse is generated.
- **Parity (PIPO_SER_PARITY_EN defined):**
  - din = 16'h0001 -> bit 17 = 1.
  - din = 16'h0003 -> bit 17 = 0.
  - done follows at cycle k+18.
